// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: bundle between the EX stage, the divide issue controller
// and the shared iterative divider core.
//   ex_*        : EX-stage instruction, operands, handshake and flush
//   core_*      : start/abort/operands toward the core, quotient/remainder back
//   ex_stall, div_result, div_res_valid, busy_rd, busy_rd_vld : toward pipeline
// slave modport is the controller's view; master is the surrounding pipeline
// plus core (the testbench drives it).
interface div_issue_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              ex_valid;
  logic              ex_is_div;
  logic [1:0]        ex_div_op;
  logic [DATA_W-1:0] ex_src1;
  logic [DATA_W-1:0] ex_src2;
  logic [4:0]        ex_rd;
  logic              ex_allow_out;
  logic              ex_flush;

  logic              core_start;
  logic              core_signed;
  logic [DATA_W-1:0] core_a;
  logic [DATA_W-1:0] core_b;
  logic              core_abort;
  logic [DATA_W-1:0] core_q;
  logic [DATA_W-1:0] core_r;

  logic              ex_stall;
  logic [DATA_W-1:0] div_result;
  logic              div_res_valid;
  logic [4:0]        busy_rd;
  logic              busy_rd_vld;

  modport slave (
    input  ex_valid, ex_is_div, ex_div_op, ex_src1, ex_src2, ex_rd,
           ex_allow_out, ex_flush, core_q, core_r,
    output core_start, core_signed, core_a, core_b, core_abort,
           ex_stall, div_result, div_res_valid, busy_rd, busy_rd_vld
  );

  modport master (
    output ex_valid, ex_is_div, ex_div_op, ex_src1, ex_src2, ex_rd,
           ex_allow_out, ex_flush, core_q, core_r,
    input  core_start, core_signed, core_a, core_b, core_abort,
           ex_stall, div_result, div_res_valid, busy_rd, busy_rd_vld
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequences the shared iterative divider for div.w/mod.w/
// div.wu/mod.wu in EX. Stalls EX until the result is ready, short-circuits
// divide-by-zero and signed overflow without using the core, aborts on EX
// flush and exports the in-flight rd for RAW hazard detection in ID.
// Ports: aclk, reset (async, active high), bus (div_issue_ctrl_if.slave).
module div_issue_ctrl #(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 33
) (
  input  logic                aclk,
  input  logic                reset,
  div_issue_ctrl_if.slave     bus
);
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic                sgn_q, sgn_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d;
  logic                start, core_start_c, core_abort_c;

  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  assign start = (state_q == S_IDLE) & bus.ex_valid & bus.ex_is_div & ~bus.ex_flush;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    rd_d         = rd_q;
    sgn_d        = sgn_q;
    a_d          = a_q;
    b_d          = b_q;
    q_d          = q_q;
    r_d          = r_q;
    core_start_c = 1'b0;
    core_abort_c = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        op_d  = bus.ex_div_op;
        rd_d  = bus.ex_rd;
        sgn_d = ~bus.ex_div_op[1];
        a_d   = bus.ex_src1;
        b_d   = bus.ex_src2;
        if (bus.ex_src2 == '0) begin
          q_d     = '1;
          r_d     = bus.ex_src1;
          state_d = S_DONE;
        end else if (!bus.ex_div_op[1] && bus.ex_src1 == MIN_NEG && bus.ex_src2 == '1) begin
          q_d     = MIN_NEG;
          r_d     = '0;
          state_d = S_DONE;
        end else begin
          core_start_c = 1'b1;
          cnt_d        = CNT_W'(DIV_CYCLES - 1);
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        // Counter is loaded on the start edge; the core result is captured on
        // the edge where it steps 1->0, i.e. DIV_CYCLES edges after start.
        if (bus.ex_flush) begin
          core_abort_c = 1'b1;
          cnt_d        = '0;
          state_d      = S_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          q_d     = bus.core_q;
          r_d     = bus.core_r;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: if (bus.ex_flush || bus.ex_allow_out) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  // Operands bypass the latch in the start cycle so they arrive with the pulse.
  assign bus.core_start    = core_start_c;
  assign bus.core_abort    = core_abort_c;
  assign bus.core_signed   = core_start_c ? ~bus.ex_div_op[1] : sgn_q;
  assign bus.core_a        = core_start_c ? bus.ex_src1 : a_q;
  assign bus.core_b        = core_start_c ? bus.ex_src2 : b_q;

  assign bus.ex_stall      = start | (state_q == S_RUN);
  assign bus.div_res_valid = (state_q == S_DONE);
  assign bus.div_result    = (state_q == S_DONE) ? (op_q[0] ? r_q : q_q) : '0;
  assign bus.busy_rd       = (state_q != S_IDLE) ? rd_q : 5'd0;
  assign bus.busy_rd_vld   = (state_q != S_IDLE) & (rd_q != 5'd0);
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: table of divide vectors with expected results and
// latencies, scoreboard queue of expected results, a behavioural divider core
// with fixed latency, plus hand sequences for flush, reset and hold cases.
module tb_div_issue_ctrl;
  localparam int DW = 32;
  localparam int DC = 33;

  logic aclk = 1'b0;
  logic reset;
  always #5 aclk = ~aclk;

  div_issue_ctrl_if #(.DATA_W(DW)) dif();
  div_issue_ctrl #(.DATA_W(DW), .DIV_CYCLES(DC)) dut (.aclk(aclk), .reset(reset), .bus(dif));

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] sb[$];

  // Behavioural core: result appears DC-1 edges after the start edge and is
  // garbage before that, so an early capture is visible.
  logic [31:0] ma, mb, mq, mr;
  logic        ms;
  int          mcnt;
  always @(posedge aclk or posedge reset) begin
    if (reset) mcnt <= 0;
    else if (dif.core_start) begin
      ma <= dif.core_a; mb <= dif.core_b; ms <= dif.core_signed; mcnt <= 1;
    end else if (dif.core_abort) mcnt <= 0;
    else if (mcnt != 0 && mcnt < 100) mcnt <= mcnt + 1;
  end
  always_comb begin
    mq = '0;
    mr = '0;
    if (mb != 0) begin
      if (ms && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
        mq = ma; mr = '0;
      end else if (ms) begin
        mq = $signed(ma) / $signed(mb); mr = $signed(ma) % $signed(mb);
      end else begin
        mq = ma / mb; mr = ma % mb;
      end
    end
  end
  assign dif.core_q = (mcnt >= DC - 1) ? mq : 32'hDEAD_BEEF;
  assign dif.core_r = (mcnt >= DC - 1) ? mr : 32'hBAD0_BAD0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          short_c;
    int          hold;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    dif.ex_valid = 0; dif.ex_is_div = 0; dif.ex_div_op = 0; dif.ex_src1 = 0;
    dif.ex_src2 = 0; dif.ex_rd = 0; dif.ex_allow_out = 0; dif.ex_flush = 0;
  endtask

  task automatic drive_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    dif.ex_valid = 1; dif.ex_is_div = 1; dif.ex_div_op = op;
    dif.ex_src1 = a; dif.ex_src2 = b; dif.ex_rd = rd;
  endtask

  task automatic do_div(input vec_t v);
    int cyc, stalls, lat;
    logic [31:0] exp;
    lat = v.short_c ? 1 : DC;
    @(posedge aclk); #1;
    drive_div(v.op, v.a, v.b, v.rd);
    #1;
    chk("core_start", {31'd0, dif.core_start}, {31'd0, !v.short_c});
    chk("stall_t0", {31'd0, dif.ex_stall}, 32'd1);
    if (!v.short_c) chk("core_a", dif.core_a, v.a);
    sb.push_back(v.exp);
    stalls = 1;
    cyc = 0;
    do begin
      @(posedge aclk); #1;
      cyc++;
      if (!dif.div_res_valid && dif.ex_stall) stalls++;
    end while (!dif.div_res_valid && cyc < 200);
    chk("latency", cyc, lat);
    chk("stall_cycles", stalls, lat);
    chk("stall_done", {31'd0, dif.ex_stall}, 32'd0);
    exp = sb.pop_front();
    chk("result", dif.div_result, exp);
    chk("busy_rd", {27'd0, dif.busy_rd}, {27'd0, v.rd});
    chk("busy_rd_vld", {31'd0, dif.busy_rd_vld}, {31'd0, v.rd != 0});
    for (int i = 0; i < v.hold; i++) begin
      @(posedge aclk); #1;
      chk("hold_result", dif.div_result, exp);
      chk("hold_valid", {31'd0, dif.div_res_valid}, 32'd1);
    end
    dif.ex_allow_out = 1;
    @(posedge aclk); #1;
    drive_idle();
    #1;
    chk("release_valid", {31'd0, dif.div_res_valid}, 32'd0);
    chk("release_busy", {31'd0, dif.busy_rd_vld}, 32'd0);
  endtask

  initial begin
    int seen;
    vecs[0]  = '{2'b00, 32'd100,       32'd7,         5'd5,  32'd14,        1'b0, 0};
    vecs[1]  = '{2'b01, 32'd100,       32'd7,         5'd6,  32'd2,         1'b0, 0};
    vecs[2]  = '{2'b00, 32'h1234,      32'd0,         5'd7,  32'hFFFF_FFFF, 1'b1, 0};
    vecs[3]  = '{2'b01, 32'h1234,      32'd0,         5'd7,  32'h1234,      1'b1, 0};
    vecs[4]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1,  32'h8000_0000, 1'b1, 0};
    vecs[5]  = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2,  32'd0,         1'b1, 0};
    vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3,  32'd0,         1'b0, 0};
    vecs[7]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4,  32'h8000_0000, 1'b0, 0};
    vecs[8]  = '{2'b00, 32'hFFFF_FF9C, 32'd7,         5'd10, 32'hFFFF_FFF2, 1'b0, 0};
    vecs[9]  = '{2'b01, 32'hFFFF_FF9C, 32'd7,         5'd11, 32'hFFFF_FFFE, 1'b0, 0};
    vecs[10] = '{2'b10, 32'hFFFF_FFFF, 32'd2,         5'd9,  32'h7FFF_FFFF, 1'b0, 5};
    vecs[11] = '{2'b00, 32'd100,       32'd7,         5'd0,  32'd14,        1'b0, 5};
    vecs[12] = '{2'b11, 32'd5,         32'd0,         5'd12, 32'd5,         1'b1, 2};

    reset = 1;
    drive_idle();
    #1;
    chk("rst_stall", {31'd0, dif.ex_stall}, 32'd0);
    chk("rst_valid", {31'd0, dif.div_res_valid}, 32'd0);
    chk("rst_busy", {31'd0, dif.busy_rd_vld}, 32'd0);
    chk("rst_core_start", {31'd0, dif.core_start}, 32'd0);
    repeat (2) @(posedge aclk);
    #1 reset = 0;

    for (int i = 0; i < 13; i++) do_div(vecs[i]);

    // Flush at RUN cycle 10: abort pulse, no result ever.
    @(posedge aclk); #1;
    drive_div(2'b00, 32'd100, 32'd7, 5'd3);
    #1 chk("fl_core_start", {31'd0, dif.core_start}, 32'd1);
    repeat (10) @(posedge aclk);
    #1 dif.ex_flush = 1;
    #1 chk("fl_abort", {31'd0, dif.core_abort}, 32'd1);
    @(posedge aclk); #1;
    drive_idle();
    #1;
    chk("fl_idle_busy", {31'd0, dif.busy_rd_vld}, 32'd0);
    chk("fl_idle_stall", {31'd0, dif.ex_stall}, 32'd0);
    chk("fl_abort_once", {31'd0, dif.core_abort}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge aclk); #1;
      if (dif.div_res_valid) seen++;
    end
    chk("fl_no_result", seen, 0);
    do_div(vecs[0]);

    // Flush together with start: nothing issued.
    @(posedge aclk); #1;
    drive_div(2'b00, 32'd50, 32'd3, 5'd13);
    dif.ex_flush = 1;
    #1;
    chk("fs_core_start", {31'd0, dif.core_start}, 32'd0);
    chk("fs_stall", {31'd0, dif.ex_stall}, 32'd0);
    @(posedge aclk); #1;
    drive_idle();
    #1 chk("fs_busy", {31'd0, dif.busy_rd_vld}, 32'd0);

    // Flush in DONE drops the result.
    @(posedge aclk); #1;
    drive_div(2'b00, 32'd9, 32'd0, 5'd4);
    @(posedge aclk); #1;
    chk("fd_valid", {31'd0, dif.div_res_valid}, 32'd1);
    dif.ex_flush = 1;
    @(posedge aclk); #1;
    drive_idle();
    #1 chk("fd_dropped", {31'd0, dif.div_res_valid}, 32'd0);

    // Async reset mid-RUN.
    @(posedge aclk); #1;
    drive_div(2'b00, 32'd100, 32'd7, 5'd8);
    repeat (5) @(posedge aclk);
    #1;
    reset = 1;
    drive_idle();
    #1;
    chk("mr_stall", {31'd0, dif.ex_stall}, 32'd0);
    chk("mr_busy_rd", {27'd0, dif.busy_rd}, 32'd0);
    chk("mr_busy_vld", {31'd0, dif.busy_rd_vld}, 32'd0);
    chk("mr_abort", {31'd0, dif.core_abort}, 32'd0);
    chk("mr_core_a", dif.core_a, 32'd0);
    @(posedge aclk); #1 reset = 0;
    do_div(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
